// File: rtl/avaliador_polinomio.sv
// Sequential polynomial evaluator using Horner's method.
// One multiply-add per clock, W-bit datapath, optional two's-complement.
module avaliador_polinomio #(
  parameter int unsigned W      = 16,
  parameter int unsigned DEGREE = 2,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                      ck,
  input  logic                      rst,
  input  logic                      inicio,
  input  logic [W-1:0]              X,
  input  logic [(DEGREE+1)*W-1:0]   coef,
  output logic                      pronto,
  output logic                      overflow,
  output logic [W-1:0]              resultado
);

  localparam int unsigned CW = (DEGREE > 1) ? $clog2(DEGREE) : 1;
  // a_N is loaded straight into acc, so only a_0..a_{N-1} are kept.
  localparam int unsigned CV = DEGREE * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    acc_q;
  logic [W-1:0]    xr_q;
  logic [CV-1:0]   cr_q;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;
  logic            pronto_q;

  logic [W-1:0]    a_sel;
  logic [2*W-1:0]  acc_ext;
  logic [2*W-1:0]  xr_ext;
  logic [2*W-1:0]  prod;
  logic [2*W:0]    a_ext;
  logic [2*W:0]    sum;
  logic [W:0]      sum_top;
  logic            step_ovf;
  logic [W-1:0]    acc_d;
  logic            ovf_d;

  // Pick coefficient a_cnt for the current Horner step.
  always_comb begin
    a_sel = '0;
    for (int k = 0; k < int'(DEGREE); k++) begin
      if (cnt_q == CW'(k)) begin
        a_sel = cr_q[k*W +: W];
      end
    end
  end

  // Full-precision multiply-add and per-step range check.
  // Operands are extended to 2W bits; the low 2W bits of the
  // product are exact for both signed and unsigned operands.
  always_comb begin
    if (SIGNED) begin
      acc_ext = {{W{acc_q[W-1]}}, acc_q};
      xr_ext  = {{W{xr_q[W-1]}}, xr_q};
      a_ext   = {{(W+1){a_sel[W-1]}}, a_sel};
    end else begin
      acc_ext = {{W{1'b0}}, acc_q};
      xr_ext  = {{W{1'b0}}, xr_q};
      a_ext   = {{(W+1){1'b0}}, a_sel};
    end
    prod = acc_ext * xr_ext;
    if (SIGNED) begin
      sum = {prod[2*W-1], prod} + a_ext;
    end else begin
      sum = {1'b0, prod} + a_ext;
    end
    sum_top = sum[2*W:W-1];
    if (SIGNED) begin
      // In range iff bits 2W..W-1 are all copies of the sign.
      step_ovf = !((&sum_top) || !(|sum_top));
    end else begin
      step_ovf = |sum_top[W:1];
    end
    acc_d = sum[W-1:0];
    ovf_d = ovf_q | step_ovf;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      xr_q     <= '0;
      cr_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (inicio) begin
            xr_q     <= X;
            cr_q     <= coef[CV-1:0];
            acc_q    <= coef[DEGREE*W +: W];
            cnt_q    <= CW'(DEGREE - 1);
            ovf_q    <= 1'b0;
            pronto_q <= 1'b0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          ovf_q <= ovf_d;
          if (cnt_q == '0) begin
            pronto_q <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          pronto_q <= 1'b0;
        end
      endcase
    end
  end

  assign pronto    = pronto_q;
  assign overflow  = ovf_q;
  assign resultado = acc_q;

endmodule

// File: tb/tb_avaliador_polinomio.sv
// Bench for avaliador_polinomio: three configurations,
// directed cases plus random stimulus against a value-level model.
module tb_avaliador_polinomio;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic        rst_n;
  logic [2:0]  ini;
  logic [15:0] x0, x1;
  logic [7:0]  x2;
  logic [47:0] c0, c1;
  logic [31:0] c2;
  logic [2:0]  pr, ov;
  logic [15:0] rs0, rs1;
  logic [7:0]  rs2;

  int nerr = 0;
  int nchk = 0;

  avaliador_polinomio #(.W(16), .DEGREE(2), .SIGNED(1'b0)) u0 (
    .ck(ck), .rst(rst_n), .inicio(ini[0]), .X(x0), .coef(c0),
    .pronto(pr[0]), .overflow(ov[0]), .resultado(rs0)
  );

  avaliador_polinomio #(.W(16), .DEGREE(2), .SIGNED(1'b1)) u1 (
    .ck(ck), .rst(rst_n), .inicio(ini[1]), .X(x1), .coef(c1),
    .pronto(pr[1]), .overflow(ov[1]), .resultado(rs1)
  );

  avaliador_polinomio #(.W(8), .DEGREE(3), .SIGNED(1'b1)) u2 (
    .ck(ck), .rst(rst_n), .inicio(ini[2]), .X(x2), .coef(c2),
    .pronto(pr[2]), .overflow(ov[2]), .resultado(rs2)
  );

  function automatic int pw(int id);
    return (id == 2) ? 8 : 16;
  endfunction

  function automatic int pdeg(int id);
    return (id == 2) ? 3 : 2;
  endfunction

  function automatic bit psg(int id);
    return id != 0;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(int id, logic [15:0] x, logic [15:0] a[4]);
    case (id)
      0: begin x0 = x; c0 = {a[2], a[1], a[0]}; end
      1: begin x1 = x; c1 = {a[2], a[1], a[0]}; end
      default: begin
        x2 = x[7:0];
        c2 = {a[3][7:0], a[2][7:0], a[1][7:0], a[0][7:0]};
      end
    endcase
  endtask

  function automatic logic [15:0] out_rs(int id);
    case (id)
      0: return rs0;
      1: return rs1;
      default: return {8'h00, rs2};
    endcase
  endfunction

  function automatic longint sval(longint v, int w, bit sg);
    longint m = 64'sd1 <<< w;
    longint r = v & (m - 1);
    if (sg && r >= m / 2) r = r - m;
    return r;
  endfunction

  // Result: true polynomial value mod 2^W (sum of a_k*x^k).
  // Overflow: exact value of every Horner step checked against range.
  function automatic void ref_eval(int id, logic [15:0] x,
                                   logic [15:0] a[4],
                                   output logic [15:0] r,
                                   output bit o);
    int     w  = pw(id);
    int     d  = pdeg(id);
    bit     sg = psg(id);
    longint m  = 64'sd1 <<< w;
    longint xm = longint'(x) & (m - 1);
    longint p  = 1;
    longint sum = 0;
    longint acc;
    longint s;
    for (int k = 0; k <= d; k++) begin
      sum = (sum + (longint'(a[k]) & (m - 1)) * p) & (m - 1);
      p   = (p * xm) & (m - 1);
    end
    r = 16'(sum);
    o = 1'b0;
    acc = sval(longint'(a[d]), w, sg);
    for (int k = d - 1; k >= 0; k--) begin
      s = acc * sval(longint'(x), w, sg) + sval(longint'(a[k]), w, sg);
      if (sg) begin
        if (s < -(m / 2) || s > m / 2 - 1) o = 1'b1;
      end else begin
        if (s >= m) o = 1'b1;
      end
      acc = sval(s, w, sg);
    end
  endfunction

  task automatic evaluate(int id, logic [15:0] x, logic [15:0] a[4],
                          logic [15:0] exp_r, bit exp_o,
                          bit toggle, bit scramble, string tag);
    int          lat;
    logic [15:0] r;
    logic [15:0] junk[4];
    @(negedge ck);
    drive(id, x, a);
    ini[id] = 1'b1;
    @(posedge ck);
    @(negedge ck);
    ini[id] = 1'b0;
    lat = 1;
    chk({tag, ".start_pr"}, 32'(pr[id]), 32'd0);
    chk({tag, ".start_ov"}, 32'(ov[id]), 32'd0);
    if (scramble) begin
      foreach (junk[i]) junk[i] = 16'($urandom);
      drive(id, 16'($urandom), junk);
    end
    while (!pr[id] && lat < 40) begin
      if (toggle) ini[id] = (lat < pdeg(id)) ? 1'($urandom) : 1'b0;
      @(negedge ck);
      lat++;
    end
    ini[id] = 1'b0;
    chk({tag, ".lat"}, 32'(lat), 32'(pdeg(id) + 1));
    chk({tag, ".res"}, 32'(out_rs(id)), 32'(exp_r));
    chk({tag, ".ovf"}, 32'(ov[id]), 32'(exp_o));
    r = out_rs(id);
    repeat (2) @(negedge ck);
    chk({tag, ".hold_pr"}, 32'(pr[id]), 32'd1);
    chk({tag, ".hold_res"}, 32'(out_rs(id)), 32'(r));
  endtask

  initial begin
    logic [15:0] a[4];
    logic [15:0] b[4];
    logic [15:0] er;
    bit          eo;
    int          lat;
    bit          seen;
    logic [15:0] xv;

    rst_n = 1'b0;
    ini   = '0;
    x0 = '0; x1 = '0; x2 = '0;
    c0 = '0; c1 = '0; c2 = '0;
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d.pr", i), 32'(pr[i]), 32'd0);
      chk($sformatf("rst%0d.ov", i), 32'(ov[i]), 32'd0);
      chk($sformatf("rst%0d.res", i), 32'(out_rs(i)), 32'd0);
    end
    @(negedge ck);
    rst_n = 1'b1;

    a = '{16'd7, 16'd5, 16'd3, 16'd0};
    evaluate(0, 16'd4, a, 16'd75, 1'b0, 1'b0, 1'b0, "d75");
    a = '{16'd0, 16'd0, 16'd1, 16'd0};
    evaluate(0, 16'd300, a, 16'd24464, 1'b1, 1'b0, 1'b0, "dovf");
    // Restart out of DONE with overflow set; also inicio noise and
    // input changes while the evaluation runs.
    a = '{16'd7, 16'd5, 16'd3, 16'd0};
    evaluate(0, 16'd4, a, 16'd75, 1'b0, 1'b1, 1'b1, "restart");
    a = '{16'hFFFF, 16'd3, 16'd1, 16'd0};
    evaluate(1, 16'hFFFE, a, 16'hFFFD, 1'b0, 1'b0, 1'b0, "dsgn");
    a = '{16'd0, 16'd0, 16'd0, 16'd1};
    evaluate(2, 16'd10, a, 16'h00E8, 1'b1, 1'b0, 1'b0, "d8b");

    // Back-to-back with inicio held high.
    a = '{16'd7, 16'd5, 16'd3, 16'd0};
    b = '{16'd1, 16'd2, 16'd3, 16'd0};
    @(negedge ck);
    drive(0, 16'd4, a);
    ini[0] = 1'b1;
    @(posedge ck);
    @(negedge ck);
    lat = 1;
    while (!pr[0] && lat < 40) begin
      @(negedge ck);
      lat++;
    end
    chk("b2b.lat1", 32'(lat), 32'd3);
    chk("b2b.res1", 32'(rs0), 32'd75);
    drive(0, 16'd10, b);
    @(negedge ck);
    chk("b2b.done1cyc", 32'(pr[0]), 32'd0);
    ini[0] = 1'b0;
    lat = 1;
    while (!pr[0] && lat < 40) begin
      @(negedge ck);
      lat++;
    end
    chk("b2b.lat2", 32'(lat), 32'd3);
    chk("b2b.res2", 32'(rs0), 32'd321);

    // Asynchronous reset in the middle of an evaluation.
    @(negedge ck);
    drive(0, 16'd4, a);
    ini[0] = 1'b1;
    @(posedge ck);
    @(negedge ck);
    ini[0] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mrst.pr", 32'(pr[0]), 32'd0);
    chk("mrst.ov", 32'(ov[0]), 32'd0);
    chk("mrst.res", 32'(rs0), 32'd0);
    @(negedge ck);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge ck);
      seen = seen | pr[0];
    end
    chk("mrst.nopr", 32'(seen), 32'd0);

    // Random stimulus against the reference model.
    for (int id = 0; id < 3; id++) begin
      for (int n = 0; n < 8; n++) begin
        foreach (a[i]) begin
          a[i] = (n % 2 == 0) ? 16'($urandom_range(0, 15))
                              : 16'($urandom);
        end
        xv = (n % 2 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
        if (n % 4 == 3) xv = 16'hFFFF;
        ref_eval(id, xv, a, er, eo);
        evaluate(id, xv, a, er, eo, 1'($urandom), 1'($urandom),
                 $sformatf("rnd%0d_%0d", id, n));
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/avaliador_polinomio.md
Name: avaliador_polinomio

Overview:
- Parametrised sequential polynomial evaluator: resultado = a_N*X^N + ... + a_1*X + a_0 over a W-bit datapath.
- Uses Horner's method with one multiply-add per clock.
- Generalises the fixed 16-bit, three-coefficient evaluator to arbitrary width and degree, plus an optional two's-complement mode.
- Keeps the same inicio/pronto/overflow handshake; drops in wherever the fixed evaluator was used.

Parameters:
- W, 16: data width of X, each coefficient and resultado.
- DEGREE, 2: polynomial degree N; legal range >= 1.
- SIGNED, 0: 0 = unsigned arithmetic; 1 = two's-complement arithmetic and overflow rules.

Ports:
- ck  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- inicio  input  1  start request, sampled on the rising edge.
- X  input  W  evaluation point; captured at start.
- coef  input  (DEGREE+1)*W  packed coefficients; a_k = coef[k*W +: W]; captured at start.
- pronto  output  1  result valid / block idle-done.
- overflow  output  1  sticky overflow flag for the current evaluation.
- resultado  output  W  evaluation result (low W bits).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, acc=0, cnt=0, pronto=0, overflow=0, resultado=0. Reset is honoured at any point, including mid-evaluation; the evaluation in progress is discarded.
- Registers:
  - acc (W bits), drives resultado directly.
  - xr (W bits), latched X.
  - cr, latched coefficients.
  - cnt, ceil(log2(DEGREE)) bits, minimum 1.
  - ovf, drives overflow.
- States: IDLE, CALC, DONE.
- IDLE or DONE with inicio=1 at an edge (start edge):
  - xr<=X, cr<=coef, acc<=a_N, cnt<=DEGREE-1, ovf<=0, pronto<=0; go to CALC.
- IDLE with inicio=0: hold. DONE with inicio=0: hold; pronto stays 1 and resultado/overflow stay stable.
- CALC, every edge:
  - Full-precision step: p = acc*xr (2W bits, signedness per SIGNED); s = p + a_cnt (2W+1 bits).
  - acc <= s[W-1:0].
  - ovf <= ovf | step_ovf.
  - If cnt==0: go to DONE, pronto<=1. Else cnt<=cnt-1.
  - inicio is ignored in CALC.
- step_ovf:
  - SIGNED=0: s >= 2^W.
  - SIGNED=1: s outside [-2^(W-1), 2^(W-1)-1].
  - Evaluated on the untruncated product and sum of each step. Later steps continue from the wrapped acc, so resultado equals the true polynomial value mod 2^W.
- Latency: start edge plus DEGREE CALC edges. pronto is first seen high after DEGREE+1 rising edges counting the start edge.
- Throughput: one evaluation per DEGREE+1 cycles. Back-to-back operation by holding inicio=1: DONE lasts exactly one cycle, then restarts.
- Input stability: X and coef may change freely after the start edge with no effect on the running evaluation.
- Simultaneous events: an inicio arriving on the same edge that leaves CALC is ignored; it takes effect on the next edge, from DONE.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan:
- W=16, DEGREE=2, SIGNED=0; X=4, a2=3, a1=5, a0=7; inicio pulsed 1 cycle -> pronto=1 exactly 3 edges after the start edge; resultado=75; overflow=0; pronto holds while inicio=0.
- Same config; X=300, a2=1, a1=0, a0=0 -> overflow=1; resultado=24464 (90000 mod 65536).
- SIGNED=1; X=0xFFFE (-2), a2=1, a1=3, a0=0xFFFF (-1) -> resultado=0xFFFD (-3); overflow=0.
- SIGNED=1, W=8, DEGREE=3; X=10, a3=1, others 0 -> overflow=1 (first violation at step 2, value 100*10); resultado=0xE8 (1000 mod 256).
- Robustness, three sub-cases:
  - rst=0 asserted mid-CALC, between edges -> all outputs 0 immediately; no pronto afterwards.
  - inicio toggled during CALC -> ignored.
  - X/coef changed after the start edge -> result unaffected.
- Restart: in DONE with overflow=1, assert inicio with a non-overflowing input -> pronto and overflow drop on the start edge; new correct result after DEGREE+1 edges.
- Back-to-back: inicio held high across two evaluations -> DONE visible for exactly one cycle between them.
